nav_msg_feeder: RTL and testbench
=================================

// Module: nav_msg_feeder
// PURPOSE
// - Upstream stage of gps_gen_core. Buffers navigation-message bytes from the host side and serialises them MSB-first onto msg_out.
// - Drives gps_gen_core.msg_in with one bit per nav-bit period (20 oversampled C/A code periods), gated by the same ena_in.
// - Its period counter stays epoch-aligned with the core's internal message counter because both reset together and count identical ena_in cycles.
// PARAMETERS
// - BIT_PERIOD  327360  ena_in cycles per nav bit (20*1023*16); must be >= 2
// - FIFO_DEPTH  4       byte FIFO entries; power of 2, >= 2
// - IDLE_BIT    1'b0    msg_out value while no data is loaded
// PORTS
// - clk_in           in   1                    clock
// - rst_in_n         in   1                    reset, asynchronous, active-low
// - ena_in           in   1                    sample enable, same as gps_gen_core.ena_in
// - byte_in          in   8                    message byte to queue
// - byte_valid_in    in   1                    byte_in is valid
// - byte_ready_out   out  1                    FIFO can accept a byte
// - clr_underrun_in  in   1                    clears underrun_out
// - msg_out          out  1                    nav bit to gps_gen_core.msg_in, registered
// - bit_strobe_out   out  1                    1-cycle pulse when msg_out presents a new data bit
// - underrun_out     out  1                    sticky: stream ran dry mid-message
// - fifo_level_out   out  $clog2(FIFO_DEPTH)+1 bytes currently queued
// BEHAVIOUR
// - Reset (async): FIFO empty, level 0, byte_ready_out 1, state EMPTY, msg_out=IDLE_BIT, bit_strobe_out 0, underrun_out 0, period cnt 0, bit_idx 0.
// - Push: byte_valid_in & byte_ready_out at a clock edge writes byte_in. byte_ready_out = (level != FIFO_DEPTH); a write attempted when full is ignored.
// - Push is independent of ena_in.
// - Period counter: width $clog2(BIT_PERIOD). Increments only when ena_in=1. Free-running, never reset by data events.
// - tick = ena_in & (cnt == BIT_PERIOD-1). On tick, cnt wraps to 0.
// - All bit changes occur only on tick, so msg_out transitions coincide with nav-bit epochs.
// - State EMPTY, on tick:
//   - FIFO non-empty: pop into shreg, msg_out <= byte[7], bit_idx <= 0, state -> ACTIVE, bit_strobe_out=1.
//   - FIFO empty: stay EMPTY; msg_out holds IDLE_BIT; no strobe; no underrun.
// - State ACTIVE, on tick:
//   - bit_idx < 7: msg_out <= shreg[6], shreg <<= 1, bit_idx++, strobe=1.
//   - bit_idx == 7 and FIFO non-empty: pop and load next byte, msg_out <= byte[7], bit_idx <= 0, strobe=1. Consecutive bytes produce gapless bits.
//   - bit_idx == 7 and FIFO empty: state -> EMPTY, msg_out <= IDLE_BIT, underrun_out <= 1, no strobe.
// - Simultaneous push and pop: level unchanged, both take effect.
// - Push into an empty FIFO on a tick cycle is not visible to that tick's pop; the byte is taken at the next tick.
// - Latency: msg_out and bit_strobe_out change on the edge where tick is sampled. A byte pushed to an empty idle block appears at the first tick after the push.
// - underrun_out: set has priority over clr_underrun_in in the same cycle.
// - ena_in=0: cnt, state and msg_out frozen. Pushes still accepted.
// - Mid-operation reset: all state returns to reset values immediately; queued bytes are lost.
// TESTING (BIT_PERIOD=4, FIFO_DEPTH=4, IDLE_BIT=0)
// - Reset, ena_in=1, push 0xA5 at cycle 1:
//   - msg_out=0 until the first tick (cycle 3 edge).
//   - Then 1,0,1,0,0,1,0,1, each held 4 cycles, with a strobe on each tick.
//   - Then 0 with underrun_out=1.
// - Push 0xFF, 0x00 back-to-back before the first tick -> 8 ones then 8 zeros with no gap. underrun_out rises only after the 16th bit.
// - Push 5 bytes with no tick -> first 4 accepted, byte_ready_out=0 and fifo_level_out=4, 5th ignored. After one byte load, ready=1 and level=3.
// - ena_in toggling 1/0 each cycle -> each bit held 8 clk_in cycles. Push with ena_in=0 still raises fifo_level_out.
// - Underrun set, then clr_underrun_in pulsed on a non-underrun cycle -> underrun_out=0 next cycle. Pulsed on the setting tick -> underrun_out stays 1.
// - Assert rst_in_n=0 mid-byte with 2 bytes queued -> msg_out=0, level=0, ready=1, strobe=0 asynchronously. After release, first tick occurs 4 enabled cycles later.

Source files
------------

// File: rtl/nav_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : nav_msg_feeder
// Purpose  : Byte FIFO that serialises nav-message bytes MSB-first onto
//            msg_out, changing only on nav-bit epochs (every BIT_PERIOD
//            enabled cycles) so msg_out stays aligned with gps_gen_core.
// Revision : 1.0  initial release
// ============================================================================
module nav_msg_feeder #(
    parameter int   BIT_PERIOD = 327360,
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                          clk_in,
    input  logic                          rst_in_n,
    input  logic                          ena_in,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid_in,
    output logic                          byte_ready_out,
    input  logic                          clr_underrun_in,
    output logic                          msg_out,
    output logic                          bit_strobe_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

    localparam int CNT_W = $clog2(BIT_PERIOD);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [LVL_W-1:0] c_LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [2:0]       c_IDX_LAST = 3'd7;

    localparam logic [0:0] c_ST_EMPTY  = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [0:0]       r_state;
    logic [0:0]       r_state_nxt;
    logic [6:0]       r_shreg;
    logic [2:0]       r_bit_idx;
    logic             r_msg;
    logic             r_strobe;
    logic             r_underrun;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // ------------------------------------------------------------------------
    // Combinational qualifiers
    // ------------------------------------------------------------------------
    logic       w_tick;
    logic       w_push;
    logic       w_fifo_empty;
    logic       w_last_bit;
    logic [7:0] w_rd_data;
    logic       w_pop;
    logic       w_shift;
    logic       w_strobe_nxt;
    logic       w_underrun_set;

    assign w_tick       = ena_in && (r_cnt == c_CNT_LAST);
    assign w_push       = byte_valid_in && (r_level != c_LVL_FULL);
    // Registered level: a byte written on a tick edge is not seen by that tick.
    assign w_fifo_empty = (r_level == '0);
    assign w_last_bit   = (r_bit_idx == c_IDX_LAST);
    assign w_rd_data    = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Epoch counter: free-running over enabled cycles only
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_cnt <= '0;
        end else if (ena_in) begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        r_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (!w_fifo_empty) r_state_nxt = c_ST_ACTIVE;
                end
                c_ST_ACTIVE: begin
                    if (w_last_bit && w_fifo_empty) r_state_nxt = c_ST_EMPTY;
                end
                default: r_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    // FSM: output decode
    always_comb begin
        w_pop          = 1'b0;
        w_shift        = 1'b0;
        w_underrun_set = 1'b0;
        if (w_tick) begin
            case (r_state)
                c_ST_EMPTY: begin
                    w_pop = !w_fifo_empty;
                end
                c_ST_ACTIVE: begin
                    if (!w_last_bit)        w_shift        = 1'b1;
                    else if (!w_fifo_empty) w_pop          = 1'b1;
                    else                    w_underrun_set = 1'b1;
                end
                default: ;
            endcase
        end
        w_strobe_nxt = w_pop || w_shift;
    end

    // ------------------------------------------------------------------------
    // Serialiser datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_msg     <= IDLE_BIT;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= w_strobe_nxt;
            if (w_pop) begin
                r_msg     <= w_rd_data[7];
                r_shreg   <= w_rd_data[6:0];
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_msg     <= r_shreg[6];
                r_shreg   <= {r_shreg[5:0], 1'b0};
                r_bit_idx <= r_bit_idx + 3'd1;
            end else if (w_underrun_set) begin
                r_msg <= IDLE_BIT;
            end
        end
    end

    // Sticky underrun; a set in the same cycle wins over a clear.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else if (clr_underrun_in) begin
            r_underrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign byte_ready_out = (r_level != c_LVL_FULL);
    assign msg_out        = r_msg;
    assign bit_strobe_out = r_strobe;
    assign underrun_out   = r_underrun;
    assign fifo_level_out = r_level;

endmodule
`default_nettype wire

// File: tb/tb_nav_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nav_msg_feeder
// Purpose  : Self-checking bench: bit scoreboard plus table and hand sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_nav_msg_feeder;

    logic       clk_in = 1'b0;
    logic       rst_in_n = 1'b0;
    logic       ena_in = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid_in = 1'b0;
    logic       byte_ready_out;
    logic       clr_underrun_in = 1'b0;
    logic       msg_out;
    logic       bit_strobe_out;
    logic       underrun_out;
    logic [2:0] fifo_level_out;

    int n_cmp  = 0;
    int n_fail = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       accept;
        logic       ready;
        logic [2:0] level;
    } vec_t;
    vec_t tbl[5];

    nav_msg_feeder #(
        .BIT_PERIOD (4),
        .FIFO_DEPTH (4),
        .IDLE_BIT   (1'b0)
    ) dut (
        .clk_in          (clk_in),
        .rst_in_n        (rst_in_n),
        .ena_in          (ena_in),
        .byte_in         (byte_in),
        .byte_valid_in   (byte_valid_in),
        .byte_ready_out  (byte_ready_out),
        .clr_underrun_in (clr_underrun_in),
        .msg_out         (msg_out),
        .bit_strobe_out  (bit_strobe_out),
        .underrun_out    (underrun_out),
        .fifo_level_out  (fifo_level_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk_in);
    endtask

    // Scoreboard: every strobe must present the next expected serial bit.
    always @(negedge clk_in) begin
        if (rst_in_n && bit_strobe_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: strobe with msg_out=%0b, expected no strobe", msg_out);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if (msg_out !== e) begin
                    n_fail++;
                    $display("FAIL sb_bit: got %0b, expected %0b", msg_out, e);
                end
            end
        end
    end

    task automatic do_reset(input logic ena_v);
        rst_in_n        = 1'b0;
        ena_in          = 1'b0;
        byte_valid_in   = 1'b0;
        clr_underrun_in = 1'b0;
        exp_q.delete();
        repeat (2) cycle();
        chk("rst_msg",      int'(msg_out),        0);
        chk("rst_strobe",   int'(bit_strobe_out), 0);
        chk("rst_underrun", int'(underrun_out),   0);
        chk("rst_ready",    int'(byte_ready_out), 1);
        chk("rst_level",    int'(fifo_level_out), 0);
        rst_in_n = 1'b1;
        ena_in   = ena_v;
    endtask

    // Called at a negedge; the byte is written at the following posedge.
    task automatic push(input logic [7:0] b, input logic accept);
        byte_in       = b;
        byte_valid_in = 1'b1;
        if (accept) for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        cycle();
        byte_valid_in = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int seen, guard, first_c, last_c;
        int sc[3];

        tbl[0] = '{8'h11, 1'b1, 1'b1, 3'd1};
        tbl[1] = '{8'h22, 1'b1, 1'b1, 3'd2};
        tbl[2] = '{8'h33, 1'b1, 1'b1, 3'd3};
        tbl[3] = '{8'h44, 1'b1, 1'b0, 3'd4};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 3'd4};

        // 0xA5 pushed at cycle 1: first tick on edge 3, bits every 4 cycles.
        do_reset(1'b1);
        pat = 8'hA5;
        for (int k = 0; k <= 35; k++) begin
            cycle();
            if (k < 3) begin
                chk($sformatf("a5_pre_msg[%0d]", k), int'(msg_out), 0);
                chk($sformatf("a5_pre_stb[%0d]", k), int'(bit_strobe_out), 0);
            end else if (k < 35) begin
                chk($sformatf("a5_msg[%0d]", k), int'(msg_out), int'(pat[7 - (k - 3) / 4]));
                chk($sformatf("a5_stb[%0d]", k), int'(bit_strobe_out), int'(((k - 3) % 4) == 0));
                chk($sformatf("a5_und[%0d]", k), int'(underrun_out), 0);
            end else begin
                chk("a5_end_msg", int'(msg_out), 0);
                chk("a5_end_stb", int'(bit_strobe_out), 0);
                chk("a5_end_und", int'(underrun_out), 1);
            end
            if (k == 0) begin
                byte_in = 8'hA5;
                byte_valid_in = 1'b1;
                for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
            end else begin
                byte_valid_in = 1'b0;
            end
        end

        // 0xFF, 0x00 back-to-back: 16 gapless bits, underrun only afterwards.
        do_reset(1'b1);
        push(8'hFF, 1'b1);
        push(8'h00, 1'b1);
        seen = 0; guard = 0; first_c = 0; last_c = 0;
        while (seen < 16 && guard < 200) begin
            cycle();
            guard++;
            if (bit_strobe_out) begin
                seen++;
                if (seen == 1) first_c = guard;
                last_c = guard;
                if (seen == 8 || seen == 16)
                    chk($sformatf("b2b_und_at_%0d", seen), int'(underrun_out), 0);
            end
        end
        chk("b2b_strobes", seen, 16);
        chk("b2b_span", last_c - first_c, 60);
        repeat (3) cycle();
        chk("b2b_und_hold", int'(underrun_out), 0);
        cycle();
        chk("b2b_und_set", int'(underrun_out), 1);
        chk("b2b_idle_msg", int'(msg_out), 0);

        // Fill with no ticks (ena_in=0): 5th byte dropped.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].b, tbl[i].accept);
            chk($sformatf("fill_ready[%0d]", i), int'(byte_ready_out), int'(tbl[i].ready));
            chk($sformatf("fill_level[%0d]", i), int'(fifo_level_out), int'(tbl[i].level));
        end
        ena_in = 1'b1;
        guard = 0;
        while (!bit_strobe_out && guard < 20) begin cycle(); guard++; end
        chk("fill_first_load", int'(bit_strobe_out), 1);
        chk("fill_level_after", int'(fifo_level_out), 3);
        chk("fill_ready_after", int'(byte_ready_out), 1);
        guard = 0;
        while (!underrun_out && guard < 200) begin cycle(); guard++; end
        chk("fill_drain_und", int'(underrun_out), 1);
        chk("fill_sb_empty", exp_q.size(), 0);

        // ena_in toggling: each bit held 8 clk cycles; push with ena_in=0 counts.
        do_reset(1'b0);
        push(8'h3C, 1'b1);
        chk("tog_level", int'(fifo_level_out), 1);
        seen = 0; guard = 0;
        while (seen < 3 && guard < 100) begin
            ena_in = ~ena_in;
            cycle();
            guard++;
            if (bit_strobe_out) begin sc[seen] = guard; seen++; end
        end
        chk("tog_strobes", seen, 3);
        chk("tog_gap0", sc[1] - sc[0], 8);
        chk("tog_gap1", sc[2] - sc[1], 8);

        // Underrun clear on a quiet cycle, then clear colliding with the set.
        do_reset(1'b1);
        push(8'h81, 1'b1);
        guard = 0;
        while (!underrun_out && guard < 100) begin cycle(); guard++; end
        chk("clr_und_set", int'(underrun_out), 1);
        clr_underrun_in = 1'b1;
        cycle();
        clr_underrun_in = 1'b0;
        chk("clr_und_cleared", int'(underrun_out), 0);
        push(8'h42, 1'b1);
        guard = 0;
        while (!bit_strobe_out && guard < 20) begin cycle(); guard++; end
        chk("clr_load_seen", int'(bit_strobe_out), 1);
        repeat (31) cycle();
        chk("clr_und_pre", int'(underrun_out), 0);
        clr_underrun_in = 1'b1;
        cycle();
        clr_underrun_in = 1'b0;
        chk("clr_set_wins", int'(underrun_out), 1);
        cycle();
        chk("clr_sticky", int'(underrun_out), 1);

        // Asynchronous reset mid-byte with 2 bytes queued.
        do_reset(1'b1);
        push(8'hC3, 1'b1);
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        guard = 0;
        while (!bit_strobe_out && guard < 20) begin cycle(); guard++; end
        repeat (5) cycle();
        chk("ar_level_before", int'(fifo_level_out), 2);
        chk("ar_msg_before", int'(msg_out), 1);
        #2;
        rst_in_n = 1'b0;
        #1;
        exp_q.delete();
        chk("ar_msg", int'(msg_out), 0);
        chk("ar_level", int'(fifo_level_out), 0);
        chk("ar_ready", int'(byte_ready_out), 1);
        chk("ar_strobe", int'(bit_strobe_out), 0);
        cycle();
        rst_in_n = 1'b1;
        push(8'h80, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk($sformatf("ar_tick_stb[%0d]", k), int'(bit_strobe_out), int'(k == 3));
        end
        chk("ar_tick_msg", int'(msg_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
